// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU scheduler slice.
package alu_pkg;
  localparam int DATA_W = 16;
  localparam int INST_W = 4;

  typedef logic [INST_W-1:0] inst_t;

  localparam inst_t FXADD = 4'd0;
  localparam inst_t FXSUB = 4'd1;
  localparam inst_t FXMUL = 4'd2;
  localparam inst_t FXMAC = 4'd3;
  localparam inst_t FXCMP = 4'd4;
  localparam inst_t FPADD = 4'd5;
  localparam inst_t FPMUL = 4'd6;
  localparam inst_t FPDIV = 4'd7;
  localparam inst_t FPCMP = 4'd8;
  localparam inst_t FPSUB = 4'd9;
  localparam inst_t OP_LEGAL_MAX = 4'd9;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  function automatic logic op_legal(input inst_t op);
    return op <= OP_LEGAL_MAX;
  endfunction
endpackage

// File: rtl/alu_sched_if.sv
// Requester, ALU and response channels of the scheduler; slave is the scheduler's view.
interface alu_sched_if;
  import alu_pkg::*;

  logic              i_req0_valid;
  inst_t             i_req0_inst;
  logic [DATA_W-1:0] i_req0_a;
  logic [DATA_W-1:0] i_req0_b;
  logic              o_req0_ready;
  logic              i_req1_valid;
  inst_t             i_req1_inst;
  logic [DATA_W-1:0] i_req1_a;
  logic [DATA_W-1:0] i_req1_b;
  logic              o_req1_ready;
  inst_t             o_alu_inst;
  logic [DATA_W-1:0] o_alu_a;
  logic [DATA_W-1:0] o_alu_b;
  logic              i_alu_busy;
  logic              i_alu_valid;
  logic [DATA_W-1:0] i_alu_data;
  logic              o_rsp_valid;
  logic              o_rsp_id;
  logic [DATA_W-1:0] o_rsp_data;
  logic              o_rsp_err;
  logic              i_rsp_ready;
  logic              o_mac_lock;

  modport slave (
    input  i_req0_valid, i_req0_inst, i_req0_a, i_req0_b,
    input  i_req1_valid, i_req1_inst, i_req1_a, i_req1_b,
    input  i_alu_busy, i_alu_valid, i_alu_data, i_rsp_ready,
    output o_req0_ready, o_req1_ready, o_alu_inst, o_alu_a, o_alu_b,
    output o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err, o_mac_lock
  );

  modport master (
    output i_req0_valid, i_req0_inst, i_req0_a, i_req0_b,
    output i_req1_valid, i_req1_inst, i_req1_a, i_req1_b,
    output i_alu_busy, i_alu_valid, i_alu_data, i_rsp_ready,
    input  o_req0_ready, o_req1_ready, o_alu_inst, o_alu_a, o_alu_b,
    input  o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err, o_mac_lock
  );
endinterface

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin grant; a held MAC lock masks off the non-owner.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_id,
  input  logic       i_lock_en,
  input  logic       i_lock_id,
  output logic [1:0] o_gnt
);
  logic [1:0] w_elig;
  logic [1:0] w_req;

  always_comb begin
    w_elig = i_lock_en ? (i_lock_id ? 2'b10 : 2'b01) : 2'b11;
    w_req  = i_req & w_elig;
    if (w_req == 2'b11) o_gnt = i_last_id ? 2'b01 : 2'b10;
    else                o_gnt = w_req;
  end
endmodule

// File: rtl/alu_sched.sv
// Shares one ALU between two requesters: arbitrate, issue, wait for result, return tagged response.
// state | meaning
// IDLE  | arbitrate and capture a command
// ISSUE | drive the command until the ALU is not busy
// WAIT  | hold the command, wait for a result or timeout
// RESP  | present the response until the consumer takes it
module alu_sched
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input logic        i_clk,
  input logic        i_rst_n,
  alu_sched_if.slave bus
);
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t            r_state;
  logic [7:0]        r_timer;
  logic              r_last_id;
  logic              r_lock;
  logic              r_lock_id;
  logic              r_id;
  inst_t             r_inst;

  logic [1:0]        w_gnt;
  logic              w_idle;
  logic              w_acc;
  logic              w_acc_id;
  inst_t             w_inst;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [7:0]        w_timer_nxt;
  logic              w_tmo;

  rr_arb2 u_arb (
    .i_req     ({bus.i_req1_valid, bus.i_req0_valid}),
    .i_last_id (r_last_id),
    .i_lock_en (r_lock),
    .i_lock_id (r_lock_id),
    .o_gnt     (w_gnt)
  );

  // Readiness is masked during reset so nothing is offered while the state is being cleared.
  assign w_idle           = (r_state == IDLE) && i_rst_n;
  assign bus.o_req0_ready = w_gnt[0] && w_idle;
  assign bus.o_req1_ready = w_gnt[1] && w_idle;
  assign w_acc    = (bus.o_req0_ready && bus.i_req0_valid) || (bus.o_req1_ready && bus.i_req1_valid);
  assign w_acc_id = bus.o_req1_ready;
  assign w_inst   = w_acc_id ? bus.i_req1_inst : bus.i_req0_inst;
  assign w_a      = w_acc_id ? bus.i_req1_a : bus.i_req0_a;
  assign w_b      = w_acc_id ? bus.i_req1_b : bus.i_req0_b;

  assign w_timer_nxt    = (r_timer == 8'hFF) ? r_timer : r_timer + 8'd1;
  assign w_tmo          = w_timer_nxt >= TMO;
  assign bus.o_mac_lock = r_lock;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state         <= IDLE;
      r_timer         <= '0;
      r_last_id       <= 1'b1;
      r_lock          <= 1'b0;
      r_lock_id       <= 1'b0;
      r_id            <= 1'b0;
      r_inst          <= '0;
      bus.o_alu_inst  <= '0;
      bus.o_alu_a     <= '0;
      bus.o_alu_b     <= '0;
      bus.o_rsp_valid <= 1'b0;
      bus.o_rsp_id    <= 1'b0;
      bus.o_rsp_data  <= '0;
      bus.o_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_id   <= w_acc_id;
          r_inst <= w_inst;
          if (op_legal(w_inst)) begin
            r_state        <= ISSUE;
            bus.o_alu_inst <= w_inst;
            bus.o_alu_a    <= w_a;
            bus.o_alu_b    <= w_b;
          end else begin
            r_state         <= RESP;
            bus.o_rsp_valid <= 1'b1;
            bus.o_rsp_id    <= w_acc_id;
            bus.o_rsp_data  <= '0;
            bus.o_rsp_err   <= 1'b1;
          end
        end
        ISSUE: if (!bus.i_alu_busy) begin
          r_state <= WAIT;
          r_timer <= '0;
        end
        WAIT: begin
          r_timer <= w_timer_nxt;
          // A result arriving on the timeout cycle is still delivered as good data.
          if (bus.i_alu_valid || w_tmo) begin
            r_state         <= RESP;
            bus.o_alu_inst  <= '0;
            bus.o_alu_a     <= '0;
            bus.o_alu_b     <= '0;
            bus.o_rsp_valid <= 1'b1;
            bus.o_rsp_id    <= r_id;
            bus.o_rsp_data  <= bus.i_alu_valid ? bus.i_alu_data : '0;
            bus.o_rsp_err   <= !bus.i_alu_valid;
          end
        end
        RESP: if (bus.i_rsp_ready) begin
          r_state         <= IDLE;
          r_last_id       <= r_id;
          bus.o_rsp_valid <= 1'b0;
          bus.o_rsp_id    <= 1'b0;
          bus.o_rsp_data  <= '0;
          bus.o_rsp_err   <= 1'b0;
          if (!bus.o_rsp_err && r_inst == FXMAC) begin
            r_lock    <= 1'b1;
            r_lock_id <= r_id;
          end else if (bus.o_rsp_err || (r_lock && r_lock_id == r_id)) begin
            r_lock <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a behavioural ALU that answers one cycle into WAIT.
module tb_alu_sched;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  alu_sched_if bus ();

  alu_sched #(.TIMEOUT(15)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  int   n_double = 0;
  int   n;
  int   cnt;
  logic id;
  logic alu_ok;
  logic acc_seen = 1'b0;
  logic pend = 1'b0;
  logic [3:0] exp_ids;

  function automatic logic [15:0] alu_f(input inst_t op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      FXADD:   return a + b;
      FXSUB:   return a - b;
      FXMAC:   return a ^ b;
      default: return a & b;
    endcase
  endfunction

  // Mid-cycle sampling of the accept handshake and of double-ready cycles.
  always @(negedge clk) begin
    #3;
    acc_seen = (bus.o_req0_ready && bus.i_req0_valid) || (bus.o_req1_ready && bus.i_req1_valid);
    if (bus.o_req0_ready && bus.o_req1_ready) n_double++;
  end

  always @(posedge clk) begin
    #1;
    bus.i_alu_valid = 1'b0;
    bus.i_alu_data  = '0;
    if (pend && alu_ok) begin
      bus.i_alu_valid = 1'b1;
      bus.i_alu_data  = alu_f(bus.o_alu_inst, bus.o_alu_a, bus.o_alu_b);
    end
    pend = acc_seen;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_accept(output logic gid);
    gid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (bus.o_req0_ready && bus.i_req0_valid) begin gid = 1'b0; return; end
      if (bus.o_req1_ready && bus.i_req1_valid) begin gid = 1'b1; return; end
      @(negedge clk);
    end
    n_total++;
    $error("FAIL accept_timeout observed=no_accept expected=accept");
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (bus.o_rsp_valid) return;
    end
    n_total++;
    $error("FAIL rsp_timeout observed=no_rsp expected=rsp");
  endtask

  function automatic logic [63:0] all_outs();
    return {6'd0, bus.o_req0_ready, bus.o_req1_ready, bus.o_alu_inst, bus.o_alu_a, bus.o_alu_b,
            bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data, bus.o_rsp_err, bus.o_mac_lock};
  endfunction

  initial begin
    rst_n = 1'b0;
    alu_ok = 1'b1;
    bus.i_req0_valid = 0; bus.i_req0_inst = '0; bus.i_req0_a = '0; bus.i_req0_b = '0;
    bus.i_req1_valid = 0; bus.i_req1_inst = '0; bus.i_req1_a = '0; bus.i_req1_b = '0;
    bus.i_alu_busy = 0; bus.i_alu_valid = 0; bus.i_alu_data = '0; bus.i_rsp_ready = 1;

    repeat (2) @(negedge clk);
    chk("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;

    // Single FXADD
    bus.i_req0_valid = 1; bus.i_req0_inst = FXADD; bus.i_req0_a = 16'h0400; bus.i_req0_b = 16'h0800;
    wait_accept(id);
    chk("t1_gnt", id, 0);
    @(posedge clk); #1; bus.i_req0_valid = 0;
    @(negedge clk);
    chk("t1_alu_cmd", {bus.o_alu_inst, bus.o_alu_a, bus.o_alu_b}, {4'd0, 16'h0400, 16'h0800});
    wait_rsp(n);
    chk("t1_latency", n + 1, 3);
    chk("t1_rsp", {bus.o_rsp_id, bus.o_rsp_data, bus.o_rsp_err}, {1'b0, 16'h0C00, 1'b0});
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Contention, both requesters FXSUB
    exp_ids = 4'b1010;
    bus.i_req0_valid = 1; bus.i_req0_inst = FXSUB; bus.i_req0_a = 16'h0500; bus.i_req0_b = 16'h0100;
    bus.i_req1_valid = 1; bus.i_req1_inst = FXSUB; bus.i_req1_a = 16'h0300; bus.i_req1_b = 16'h0100;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(n);
      chk("cont_id", bus.o_rsp_id, exp_ids[i]);
      chk("cont_data", bus.o_rsp_data, exp_ids[i] ? 16'h0200 : 16'h0400);
    end
    bus.i_req0_valid = 0; bus.i_req1_valid = 0;

    // MAC lock chain on req0 while req1 waits
    bus.i_req0_valid = 1; bus.i_req0_inst = FXMAC; bus.i_req0_a = 16'h0F00; bus.i_req0_b = 16'h00F0;
    bus.i_req1_valid = 1; bus.i_req1_inst = FXADD; bus.i_req1_a = 16'h1000; bus.i_req1_b = 16'h0234;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(n);
      chk("mac_id", bus.o_rsp_id, 0);
      chk("mac_data", bus.o_rsp_data, (i < 3) ? 16'h0FF0 : 16'h0003);
      chk("mac_lock", bus.o_mac_lock, (i == 0) ? 1'b0 : 1'b1);
      if (i == 2) begin bus.i_req0_inst = FXADD; bus.i_req0_a = 16'h0001; bus.i_req0_b = 16'h0002; end
      if (i == 3) bus.i_req0_valid = 0;
    end
    wait_rsp(n);
    chk("mac_after_rsp", {bus.o_rsp_id, bus.o_rsp_data, bus.o_mac_lock}, {1'b1, 16'h1234, 1'b0});
    bus.i_req1_valid = 0;

    // Illegal opcode from req1
    bus.i_req1_valid = 1; bus.i_req1_inst = 4'hC; bus.i_req1_a = 16'hFFFF; bus.i_req1_b = 16'hFFFF;
    wait_accept(id);
    chk("ill_gnt", id, 1);
    @(posedge clk); #1; bus.i_req1_valid = 0;
    chk("ill_alu", {bus.o_alu_inst, bus.o_alu_a, bus.o_alu_b}, 36'd0);
    chk("ill_rsp", {bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data, bus.o_rsp_err}, {1'b1, 1'b1, 16'h0, 1'b1});
    @(posedge clk); #1;
    chk("ill_after", {bus.o_rsp_valid, bus.o_mac_lock}, 2'b00);

    // Timeout with a busy ALU at issue, then response backpressure
    alu_ok = 0; bus.i_rsp_ready = 0; bus.i_alu_busy = 1;
    bus.i_req0_valid = 1; bus.i_req0_inst = FXMUL; bus.i_req0_a = 16'h1234; bus.i_req0_b = 16'h5678;
    wait_accept(id);
    chk("tmo_gnt", id, 0);
    @(posedge clk); #1;
    bus.i_req0_valid = 0;
    bus.i_req1_valid = 1; bus.i_req1_inst = FXADD; bus.i_req1_a = 16'h0001; bus.i_req1_b = 16'h0001;
    @(posedge clk); #1;
    chk("busy_hold", {bus.o_alu_inst, bus.o_alu_a}, {FXMUL, 16'h1234});
    @(posedge clk); #1;
    bus.i_alu_busy = 0;
    wait_rsp(n);
    chk("tmo_latency", n, 17);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_stable", {bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data, bus.o_rsp_err,
                        bus.o_req0_ready, bus.o_req1_ready}, {1'b1, 1'b0, 16'h0, 1'b1, 2'b00});
    end
    bus.i_rsp_ready = 1; bus.i_req1_valid = 0;
    @(posedge clk); #1;
    chk("bp_release", {bus.o_rsp_valid, bus.o_mac_lock}, 2'b00);

    // Reset in the middle of WAIT
    bus.i_req1_valid = 1; bus.i_req1_inst = FXADD; bus.i_req1_a = 16'h0011; bus.i_req1_b = 16'h0022;
    wait_accept(id);
    chk("rst_pre_gnt", id, 1);
    @(posedge clk); #1; bus.i_req1_valid = 0;
    @(posedge clk); #1;
    chk("rst_pre_wait", bus.o_alu_a, 16'h0011);
    @(negedge clk); rst_n = 0;
    @(posedge clk); #1;
    chk("rst_mid_outs", all_outs(), 64'd0);
    rst_n = 1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.o_rsp_valid) cnt++;
    end
    chk("rst_no_rsp", cnt, 0);
    alu_ok = 1;
    bus.i_req0_valid = 1; bus.i_req0_inst = FXADD; bus.i_req0_a = 16'h0001; bus.i_req0_b = 16'h0001;
    bus.i_req1_valid = 1; bus.i_req1_inst = FXADD; bus.i_req1_a = 16'h0002; bus.i_req1_b = 16'h0002;
    wait_accept(id);
    chk("rst_next_gnt", id, 0);
    @(posedge clk); #1; bus.i_req0_valid = 0; bus.i_req1_valid = 0;
    wait_rsp(n);
    chk("rst_next_rsp", {bus.o_rsp_id, bus.o_rsp_data, bus.o_rsp_err}, {1'b0, 16'h0002, 1'b0});

    chk("no_double_ready", n_double, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
